// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer: FSM states,
// ALU operation encodings and the iteration count.
package muldiv_pkg;

   localparam int unsigned ITERATIONS = 32;

   localparam logic [1:0] ALU_OP_AND = 2'b00;
   localparam logic [1:0] ALU_OP_OR  = 2'b01;
   localparam logic [1:0] ALU_OP_ADD = 2'b10;
   localparam logic [1:0] ALU_OP_SLT = 2'b11;

   // StFix is only reachable when SIGNED_MULDIV_EN is defined.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10,
      StFix  = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. Owns HI/LO and borrows an external
// ripple ALU as its adder/subtractor: shift-and-add multiply and restoring
// divide, one ALU pass per cycle, 32 iterations.
// Optional feature macro: SIGNED_MULDIV_EN adds the i_signed port and a FIX
// state that restores result signs after a magnitude-only run.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic             i_is_div,
`ifdef SIGNED_MULDIV_EN
   input  logic             i_signed,
`endif
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic             o_alu_a_invert,
   output logic             o_alu_b_negate,
   output logic [1:0]       o_alu_op,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic             i_alu_carry_out
);

   state_e             r_state;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_rt;
   logic [CNT_W-1:0]   r_count;
   logic               r_is_div;
   logic               r_div_by_zero;

   logic [WIDTH-1:0]   w_rem_shift;
   logic               w_accept;
   logic [WIDTH-1:0]   w_op_rs;
   logic [WIDTH-1:0]   w_op_rt;
   logic               w_last_iter;
   state_e             w_after_run;

`ifdef SIGNED_MULDIV_EN
   logic               r_signed;
   logic               r_neg_quo;
   logic               r_neg_rem;
   logic [2*WIDTH-1:0] w_prod_neg;

   // Magnitudes come from local negators so the shared ALU stays free at Start.
   assign w_op_rs     = (i_signed && i_rs[WIDTH-1]) ? (~i_rs + 1'b1) : i_rs;
   assign w_op_rt     = (i_signed && i_rt[WIDTH-1]) ? (~i_rt + 1'b1) : i_rt;
   assign w_prod_neg  = ~{r_hi, r_lo} + 1'b1;
   assign w_after_run = r_signed ? StFix : StDone;
`else
   assign w_op_rs     = i_rs;
   assign w_op_rt     = i_rt;
   assign w_after_run = StDone;
`endif

   // Partial remainder shifted left by one, pulling in the next dividend bit.
   assign w_rem_shift = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
   // A set Hi[31] means the shifted remainder exceeds 32 bits, so it is >= divisor.
   assign w_accept    = r_hi[WIDTH-1] | i_alu_carry_out;
   assign w_last_iter = (r_count == CNT_W'(ITERATIONS - 1));

   assign o_busy         = (r_state != StIdle);
   assign o_done         = (r_state == StDone);
   assign o_div_by_zero  = r_div_by_zero;
   assign o_hi           = r_hi;
   assign o_lo           = r_lo;
   assign o_alu_a_invert = 1'b0;
   assign o_alu_op       = ALU_OP_ADD;

   // ALU operand steering: only RUN uses the ALU; other states present zeros.
   always_comb begin
      o_alu_a        = '0;
      o_alu_b        = '0;
      o_alu_b_negate = 1'b0;
      if (r_state == StRun) begin
         if (r_is_div) begin
            o_alu_a        = w_rem_shift;
            o_alu_b        = r_rt;
            o_alu_b_negate = 1'b1;
         end else begin
            o_alu_a = r_hi;
            o_alu_b = r_lo[0] ? r_rt : '0;
         end
      end
   end

   // Sequencer FSM with HI/LO datapath; synchronous active-low reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state       <= StIdle;
         r_hi          <= '0;
         r_lo          <= '0;
         r_rt          <= '0;
         r_count       <= '0;
         r_is_div      <= 1'b0;
         r_div_by_zero <= 1'b0;
`ifdef SIGNED_MULDIV_EN
         r_signed      <= 1'b0;
         r_neg_quo     <= 1'b0;
         r_neg_rem     <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_is_div      <= i_is_div;
                  r_rt          <= w_op_rt;
                  r_count       <= '0;
                  r_div_by_zero <= 1'b0;
`ifdef SIGNED_MULDIV_EN
                  r_signed      <= i_signed;
                  r_neg_quo     <= i_signed & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
                  r_neg_rem     <= i_signed & i_rs[WIDTH-1];
`endif
                  if (i_is_div && (i_rt == '0)) begin
                     // Divide by zero skips RUN (and FIX) and returns raw Rs.
                     r_hi          <= i_rs;
                     r_lo          <= '1;
                     r_div_by_zero <= 1'b1;
                     r_state       <= StDone;
                  end else begin
                     r_hi    <= '0;
                     r_lo    <= w_op_rs;
                     r_state <= StRun;
                  end
               end
            end
            StRun: begin
               if (r_is_div) begin
                  r_hi <= w_accept ? i_alu_result : w_rem_shift;
                  r_lo <= {r_lo[WIDTH-2:0], w_accept};
               end else begin
                  {r_hi, r_lo} <= {i_alu_carry_out, i_alu_result, r_lo[WIDTH-1:1]};
               end
               r_count <= r_count + 1'b1;
               if (w_last_iter) begin
                  r_state <= w_after_run;
               end
            end
            StFix: begin
`ifdef SIGNED_MULDIV_EN
               if (r_is_div) begin
                  if (r_neg_quo) r_lo <= ~r_lo + 1'b1;
                  if (r_neg_rem) r_hi <= ~r_hi + 1'b1;
               end else if (r_neg_quo) begin
                  {r_hi, r_lo} <= w_prod_neg;
               end
`endif
               r_state <= StDone;
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural stand-in for the shared
// ripple ALU. Signed cases are built only with SIGNED_MULDIV_EN.
module tb_muldiv_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        is_div;
   logic        sgn;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_a_invert;
   logic        alu_b_negate;
   logic [1:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_carry_out;

   logic [31:0] alu_a_eff;
   logic [31:0] alu_b_eff;
   logic [32:0] alu_sum;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_seq #(
      .WIDTH (32),
      .CNT_W (5)
   ) u_dut (
      .i_clock         (clk),
      .i_reset_n       (reset_n),
      .i_start         (start),
      .i_is_div        (is_div),
`ifdef SIGNED_MULDIV_EN
      .i_signed        (sgn),
`endif
      .i_rs            (rs),
      .i_rt            (rt),
      .o_busy          (busy),
      .o_done          (done),
      .o_div_by_zero   (dbz),
      .o_hi            (hi),
      .o_lo            (lo),
      .o_alu_a         (alu_a),
      .o_alu_b         (alu_b),
      .o_alu_a_invert  (alu_a_invert),
      .o_alu_b_negate  (alu_b_negate),
      .o_alu_op        (alu_op),
      .i_alu_result    (alu_result),
      .i_alu_carry_out (alu_carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU in ADD mode: A' + B' + BNegate, with carry out.
   always_comb begin
      alu_a_eff = alu_a_invert ? ~alu_a : alu_a;
      alu_b_eff = alu_b_negate ? ~alu_b : alu_b;
      alu_sum   = {1'b0, alu_a_eff} + {1'b0, alu_b_eff} + {32'd0, alu_b_negate};
   end
   assign alu_result    = alu_sum[31:0];
   assign alu_carry_out = alu_sum[32];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands with Start for one edge; leaves time at posedge + 1.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic d,
                           input logic s);
      rs     = a;
      rt     = b;
      is_div = d;
      sgn    = s;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Count cycles from the Start edge until Done; optionally pokes Start at cycle poke.
   task automatic wait_done(input int poke, output int lat, output bit busy_ok,
                            output bit op_ok);
      lat     = 1;
      busy_ok = 1'b1;
      op_ok   = 1'b1;
      while (!done && lat < 100) begin
         if (!busy) busy_ok = 1'b0;
         if (alu_op != 2'b10 || alu_a_invert) op_ok = 1'b0;
         if (lat == poke) begin
            rs     = 32'd1000;
            rt     = 32'd3;
            is_div = 1'b1;
            start  = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic d, input logic s, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dbz, input int poke);
      int lat;
      bit busy_ok;
      bit op_ok;
      start_op(a, b, d, s);
      wait_done(poke, lat, busy_ok, op_ok);
      check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, " busy"}, {63'd0, busy_ok & busy}, 64'd1);
      check_eq({tag, " aluop"}, {63'd0, op_ok}, 64'd1);
      check_eq({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
      check_eq({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
      check_eq({tag, " dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
      @(posedge clk);
      #1;
      check_eq({tag, " idle busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      bit seen_done;
      reset_n = 1'b0;
      start   = 1'b0;
      is_div  = 1'b0;
      sgn     = 1'b0;
      rs      = 32'hDEAD_BEEF;
      rt      = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset busy", {63'd0, busy}, 64'd0);
      check_eq("reset done", {63'd0, done}, 64'd0);
      check_eq("reset dbz", {63'd0, dbz}, 64'd0);
      check_eq("reset hilo", {hi, lo}, 64'd0);
      check_eq("reset alu", {alu_a, alu_b}, 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("mul 7x6", 32'd7, 32'd6, 1'b0, 1'b0, 33, 32'd0, 32'd42, 1'b0, 0);
      run_op("mul ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 33,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
      run_op("mul shift", 32'h1234_5678, 32'h10, 1'b0, 1'b0, 33,
             32'h1, 32'h2345_6780, 1'b0, 0);
      run_op("div 100/7", 32'd100, 32'd7, 1'b1, 1'b0, 33, 32'd2, 32'd14, 1'b0, 0);
      run_op("div ff/1", 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 33, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
      run_op("div 5/7", 32'd5, 32'd7, 1'b1, 1'b0, 33, 32'd5, 32'd0, 1'b0, 0);
      check_eq("idle alu", {alu_a, alu_b}, 64'd0);
      check_eq("idle negate", {63'd0, alu_b_negate}, 64'd0);

      run_op("div by 0", 32'd5, 32'd0, 1'b1, 1'b0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("dbz held", {63'd0, dbz}, 64'd1);
      check_eq("hold hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
      // Next accepted Start clears DivByZero.
      run_op("mul after dbz", 32'd7, 32'd6, 1'b0, 1'b0, 33, 32'd0, 32'd42, 1'b0, 0);

      // Start pulsed mid-operation at cycle 10 is ignored.
      run_op("busy start", 32'd7, 32'd6, 1'b0, 1'b0, 33, 32'd0, 32'd42, 1'b0, 10);

      // Reset asserted at cycle 15 of an operation discards it.
      start_op(32'd3, 32'd4, 1'b0, 1'b0);
      repeat (14) @(posedge clk);
      #1;
      check_eq("pre-reset busy", {63'd0, busy}, 64'd1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_eq("midrst busy", {63'd0, busy}, 64'd0);
      check_eq("midrst hilo", {hi, lo}, 64'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) seen_done = 1'b1;
         @(posedge clk);
         #1;
      end
      check_eq("midrst quiet", {63'd0, seen_done}, 64'd0);

`ifdef SIGNED_MULDIV_EN
      run_op("smul -7x2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 34,
             32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 0);
      run_op("sdiv -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 34,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("sdiv 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 34,
             32'd1, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("sdiv by 0", 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, 1,
             32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
      run_op("unsigned path", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 33,
             32'h1, 32'hFFFF_FFF2, 1'b0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MIPS CPU.
- Holds the HI/LO pair and drives an external 32-bit ripple ALU (AND/OR/ADD/SLT, AInvert/BNegate, CarryOut) as its shared adder/subtractor.
- Performs shift-and-add multiply and restoring divide, one ALU pass per cycle.
- Sits beside the ALU in EX; the pipeline stalls on Busy.

Parameters:
- WIDTH, 32, operand/ALU width; only 32 supported; must match the ALU instance.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  request pulse; accepted only in IDLE.
- IsDiv  in  1  0 = multiply, 1 = divide; sampled with Start.
- Rs  in  32  multiplicand / dividend.
- Rt  in  32  multiplier / divisor.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse; Hi/Lo valid from this cycle.
- DivByZero  out  1  set with Done when IsDiv and Rt==0; held until next accepted Start.
- Hi  out  32  HI register (product high / remainder).
- Lo  out  32  LO register (product low / quotient).
- AluA  out  32  to ALU A.
- AluB  out  32  to ALU B.
- AluAInvert  out  1  to ALU AInvert; always 0.
- AluBNegate  out  1  to ALU BNegate.
- AluOp  out  2  to ALU Op; always 2'b10 (ADD).
- AluResult  in  32  from ALU Result.
- AluCarryOut  in  1  from ALU CarryOut.

Behaviour:
- Reset (Reset_n=0 at edge, including mid-operation):
  - state = IDLE; Hi, Lo, count, operand regs = 0.
  - Busy = Done = DivByZero = 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE, plus FIX only with the optional feature.
- ALU outputs in IDLE/DONE: AluA = 0, AluB = 0, AluBNegate = 0.
- IDLE:
  - Start=1 latches IsDiv and Rt into the operand regs, clears DivByZero, count = 0.
  - Multiply: Hi = 0, Lo = Rs; go to RUN.
  - Divide, Rt != 0: Hi = 0, Lo = Rs; go to RUN.
  - Divide, Rt == 0: Hi = Rs, Lo = 32'hFFFFFFFF, DivByZero = 1; go to DONE (Done one cycle after Start).
- RUN, multiply (per cycle):
  - AluA = Hi, AluB = (Lo[0] ? Rt_reg : 0), AluBNegate = 0.
  - {Hi,Lo} <= {AluCarryOut, AluResult, Lo[31:1]}.
- RUN, divide (per cycle):
  - R' = {Hi[30:0], Lo[31]}; AluA = R', AluB = Rt_reg, AluBNegate = 1.
  - accept = Hi[31] | AluCarryOut.
  - Hi <= accept ? AluResult : R'; Lo <= {Lo[30:0], accept}.
- Iteration count: count increments each RUN cycle; after the cycle with count == 31, go to DONE (exactly 32 RUN cycles).
- DONE: Done = 1 for one cycle, then return to IDLE.
- Latency:
  - Start edge to Done cycle is 33 cycles.
  - Start is accepted again in the cycle after DONE.
  - Start while Busy is ignored; no queueing.
- Outputs: Hi/Lo update every RUN cycle (intermediate values visible). Consumers read them only on Done or later.
- Hold: Hi/Lo hold their value in IDLE until the next accepted Start.
- Arithmetic is unsigned unless the feature below is enabled.
  - Product is the full 64 bits; no overflow flag.
  - Quotient truncates; remainder < divisor.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- Enabled:
  - Adds input port Signed (1 bit, sampled with Start).
  - If Signed=1, operands are replaced by their magnitudes at Start using local negation logic (not the ALU); result sign flags are recorded.
  - After RUN, state FIX negates the 64-bit product (if signs differ), or the quotient (signs differ) and the remainder (dividend negative). Then go to DONE.
  - Signed latency is 34 cycles.
  - Signed divide-by-zero takes the same path as unsigned, with no FIX.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed=0 behaves exactly as unsigned with 33-cycle latency.
- Disabled: no Signed port, no FIX state; MULT/DIV are treated as MULTU/DIVU.

Decomposition:
- Shared package muldiv_pkg:
  - state enum (IDLE, RUN, DONE, FIX).
  - ALU op constants ALU_OP_AND=2'b00, ALU_OP_OR=2'b01, ALU_OP_ADD=2'b10, ALU_OP_SLT=2'b11.
  - ITERATIONS=32.
- No sub-module. The ALU stays external so it can be shared; the counter and negators are inline.

Test Plan:
- Multiply: Rs=7, Rt=6, IsDiv=0 -> Done at cycle 33; Hi=0, Lo=42; Busy high cycles 1-33.
- Multiply: Rs=Rt=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001; AluOp constant 2'b10 throughout.
- Divide: Rs=100, Rt=7 -> Lo=14, Hi=2, DivByZero=0; Rs=32'hFFFFFFFF, Rt=1 -> Lo=32'hFFFFFFFF, Hi=0.
- Divide by zero: Rs=5, Rt=0 -> Done the cycle after Start, DivByZero=1, Hi=5, Lo=32'hFFFFFFFF; next Start clears DivByZero.
- Start pulsed while Busy (cycle 10) -> ignored, result unchanged; Reset_n=0 at cycle 15 -> IDLE, Hi=Lo=0, Busy=0, no Done.
- SIGNED_MULDIV_EN, Signed=1:
  - Rs=-7, Rt=2 multiply -> {Hi,Lo} = -14 (Hi=32'hFFFFFFFF, Lo=32'hFFFFFFF2), Done at cycle 34.
  - Rs=-7, Rt=2 divide -> Lo=-3, Hi=-1.
